// File: rtl/lcm_ci.sv
// lcm_ci: LCM stage behind the GCD unit, forms (a / gcd) * b.
// Restoring divide (W steps) then one registered 2W-bit multiply.
// Ports: gated_clk, reset (async, active-high), clk_en,
//   in_valid/in_ready with op_a/op_b/op_g, out_valid/out_ready with
//   lcm_lo/lcm_hi/ovf/err, busy.
// Optional macro LCM_REM_CHECK_EN: err flags a nonzero final
//   remainder; when undefined err is tied to 0.
module lcm_ci #(
  parameter int W = 32
) (
  input  logic         gated_clk,
  input  logic         reset,
  input  logic         clk_en,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] op_a,
  input  logic [W-1:0] op_b,
  input  logic [W-1:0] op_g,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] lcm_lo,
  output logic [W-1:0] lcm_hi,
  output logic         ovf,
  output logic         err,
  output logic         busy
);

  localparam int CW = (W > 1) ? $clog2(W) : 1;

  typedef enum logic [1:0] {
    IDLE, DIV, MUL, HOLD
  } state_t;

  state_t state, state_nx;

  logic [W-1:0]   a_q, b_q, g_q;
  logic [W-1:0]   quot, rem;
  logic [CW-1:0]  cnt;
  logic [W:0]     rem_sh;
  logic           rem_ge;
  logic [W-1:0]   rem_nx;
  logic [2*W-1:0] prod;
  logic           zero_op;

  assign zero_op = (op_a == '0) || (op_b == '0) ||
                   (op_g == '0);

  // Remainder path is one bit wider than g so the
  // compare stays correct when g exceeds 2^(W-1).
  always_comb begin
    rem_sh = {rem, a_q[cnt]};
    rem_ge = rem_sh >= {1'b0, g_q};
    rem_nx = rem_sh[W-1:0];
    if (rem_ge)
      rem_nx = W'(rem_sh - {1'b0, g_q});
  end

  assign prod = {{W{1'b0}}, quot} * {{W{1'b0}}, b_q};

  always_ff @(posedge gated_clk or posedge reset) begin
    if (reset)
      state <= IDLE;
    else if (clk_en)
      state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: if (in_valid)
              state_nx = zero_op ? HOLD : DIV;
      DIV:  if (cnt == '0)
              state_nx = MUL;
      MUL:  state_nx = HOLD;
      HOLD: if (out_ready)
              state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    in_ready = (state == IDLE);
    busy     = (state != IDLE);
  end

  always_ff @(posedge gated_clk or posedge reset) begin
    if (reset) begin
      a_q       <= '0;
      b_q       <= '0;
      g_q       <= '0;
      quot      <= '0;
      rem       <= '0;
      cnt       <= '0;
      lcm_lo    <= '0;
      lcm_hi    <= '0;
      ovf       <= 1'b0;
      out_valid <= 1'b0;
    end else if (clk_en) begin
      unique case (state)
        IDLE: if (in_valid) begin
          a_q  <= op_a;
          b_q  <= op_b;
          g_q  <= op_g;
          quot <= '0;
          rem  <= '0;
          cnt  <= CW'(W - 1);
          if (zero_op) begin
            lcm_lo    <= '0;
            lcm_hi    <= '0;
            ovf       <= 1'b0;
            out_valid <= 1'b1;
          end
        end
        DIV: begin
          rem <= rem_nx;
          if (rem_ge)
            quot[cnt] <= 1'b1;
          cnt <= cnt - 1'b1;
        end
        MUL: begin
          lcm_lo    <= prod[W-1:0];
          lcm_hi    <= prod[2*W-1:W];
          ovf       <= (prod[2*W-1:W] != '0);
          out_valid <= 1'b1;
        end
        HOLD: if (out_ready)
          out_valid <= 1'b0;
        default: ;
      endcase
    end
  end

`ifdef LCM_REM_CHECK_EN
  logic err_q;

  always_ff @(posedge gated_clk or posedge reset) begin
    if (reset)
      err_q <= 1'b0;
    else if (clk_en) begin
      unique case (state)
        IDLE: if (in_valid)
          err_q <= 1'b0;
        MUL:  err_q <= (rem != '0);
        HOLD: if (out_ready)
          err_q <= 1'b0;
        default: ;
      endcase
    end
  end

  assign err = err_q;
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_lcm_ci.sv
// tb_lcm_ci: directed bench for lcm_ci.
// Table of operand triples plus hand sequences for stalls/reset.
module tb_lcm_ci;

`ifdef LCM_REM_CHECK_EN
  localparam logic REM_EN = 1'b1;
`else
  localparam logic REM_EN = 1'b0;
`endif

  logic        gated_clk = 1'b0;
  logic        reset;
  logic        clk_en;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] op_a, op_b, op_g;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] lcm_lo, lcm_hi;
  logic        ovf, err, busy;

  int checks = 0;
  int failures = 0;

  lcm_ci #(.W(32)) dut (
    .gated_clk (gated_clk),
    .reset     (reset),
    .clk_en    (clk_en),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op_a      (op_a),
    .op_b      (op_b),
    .op_g      (op_g),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .lcm_lo    (lcm_lo),
    .lcm_hi    (lcm_hi),
    .ovf       (ovf),
    .err       (err),
    .busy      (busy)
  );

  always #5 gated_clk = ~gated_clk;

  typedef struct {
    logic [31:0] a, b, g;
    int          stall;
    logic [31:0] lo, hi;
    logic        ovf, er;
    int          lat;
  } vec_t;

  vec_t vecs[10];

  task automatic chk(input string name,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h",
               name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge gated_clk);
    #1;
  endtask

  task automatic run_op(input vec_t v, input int idx);
    int cyc;
    op_a     = v.a;
    op_b     = v.b;
    op_g     = v.g;
    in_valid = 1'b1;
    clk_en   = 1'b1;
    cyc      = 0;
    while (!out_valid && cyc < 200) begin
      step();
      cyc++;
      if (cyc == 1)
        in_valid = 1'b0;
      if (v.stall > 0 && cyc == 6)
        clk_en = 1'b0;
      if (v.stall > 0 && cyc == 6 + v.stall)
        clk_en = 1'b1;
    end
    in_valid = 1'b0;
    clk_en   = 1'b1;
    chk($sformatf("v%0d_lat", idx), 64'(cyc), 64'(v.lat));
    chk($sformatf("v%0d_lcm", idx),
        {lcm_hi, lcm_lo}, {v.hi, v.lo});
    chk($sformatf("v%0d_ovf", idx), 64'(ovf), 64'(v.ovf));
    chk($sformatf("v%0d_err", idx), 64'(err), 64'(v.er));
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk($sformatf("v%0d_acc", idx),
        {62'd0, in_ready, out_valid}, 64'b10);
  endtask

  task automatic chk_reset_vals(input string name);
    chk(name,
        {in_ready, out_valid, ovf, err, busy,
         lcm_hi, lcm_lo},
        {5'b10000, 64'd0});
  endtask

  initial begin
    int cyc;
    int bad;

    vecs[0] = '{32'd12, 32'd18, 32'd6, 0,
                32'd36, 32'd0, 1'b0, 1'b0, 34};
    vecs[1] = '{32'hFFFFFFFF, 32'hFFFFFFFE, 32'd1, 0,
                32'h00000002, 32'hFFFFFFFD, 1'b1, 1'b0, 34};
    vecs[2] = '{32'd0, 32'd5, 32'd5, 0,
                32'd0, 32'd0, 1'b0, 1'b0, 1};
    vecs[3] = '{32'd0, 32'd0, 32'd0, 0,
                32'd0, 32'd0, 1'b0, 1'b0, 1};
    vecs[4] = '{32'd21, 32'd6, 32'd3, 10,
                32'd42, 32'd0, 1'b0, 1'b0, 44};
    vecs[5] = '{32'd7, 32'd13, 32'd1, 0,
                32'd91, 32'd0, 1'b0, 1'b0, 34};
    vecs[6] = '{32'h00010000, 32'h00010000, 32'd1, 0,
                32'd0, 32'd1, 1'b1, 1'b0, 34};
    vecs[7] = '{32'hFFFFFFFE, 32'hFFFFFFFE, 32'hFFFFFFFE, 0,
                32'hFFFFFFFE, 32'd0, 1'b0, 1'b0, 34};
    vecs[8] = '{32'd10, 32'd4, 32'd3, 0,
                32'd12, 32'd0, 1'b0, REM_EN, 34};
    vecs[9] = '{32'd5, 32'd0, 32'd5, 0,
                32'd0, 32'd0, 1'b0, 1'b0, 1};

    reset     = 1'b1;
    clk_en    = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    op_a      = '0;
    op_b      = '0;
    op_g      = '0;
    repeat (2) step();
    chk_reset_vals("reset_hold");
    reset = 1'b0;
    clk_en = 1'b1;
    step();
    chk_reset_vals("after_reset");

    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk("stray_out_ready",
        {62'd0, in_ready, out_valid}, 64'b10);

    foreach (vecs[i])
      run_op(vecs[i], i);

    // Hold with back-pressure; in_valid must be ignored.
    op_a = 32'd12; op_b = 32'd18; op_g = 32'd6;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    cyc = 1;
    while (!out_valid && cyc < 200) begin
      step();
      cyc++;
    end
    chk("hold_lat", 64'(cyc), 64'd34);
    op_a = 32'd0; op_b = 32'd0; op_g = 32'd0;
    in_valid = 1'b1;
    bad = 0;
    for (int k = 0; k < 5; k++) begin
      step();
      if (!out_valid || in_ready || lcm_lo != 32'd36 ||
          lcm_hi != 32'd0)
        bad++;
    end
    chk("hold_stable", 64'(bad), 64'd0);
    in_valid = 1'b0;
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk("hold_release",
        {in_ready, out_valid, busy, lcm_lo},
        {3'b100, 32'd36});

    // Reset during DIV.
    op_a = 32'd12; op_b = 32'd18; op_g = 32'd6;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    repeat (15) step();
    chk("pre_reset_busy", 64'(busy), 64'd1);
    #2 reset = 1'b1;
    #1;
    chk_reset_vals("mid_div_reset");
    @(negedge gated_clk);
    reset = 1'b0;
    step();
    chk_reset_vals("post_reset");
    run_op('{32'd4, 32'd6, 32'd2, 0,
             32'd12, 32'd0, 1'b0, 1'b0, 34}, 10);

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
